// File: rtl/psum_collector.sv
// psum_collector: per-column FIFOs that realign skewed MAC-row partial sums into whole rows (FWFT output).
// Defining PSUM_COLLECTOR_OVF_FLAG_EN adds a sticky o_ovf flag for writes dropped on a full column.
module psum_collector #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready
`ifdef PSUM_COLLECTOR_OVF_FLAG_EN
  ,
  output logic                   o_ovf
`endif
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] ptr_one = {{aw{1'b0}}, 1'b1};

  logic [col-1:0] full;
  logic [col-1:0] nonempty;
  logic           pop;

  assign o_valid = &nonempty;
  assign o_full  = |full;
  assign o_ready = ~o_full;
  // A row pops only when every column has its entry, so all rptrs stay in lockstep.
  assign pop     = rd & o_valid;

  for (genvar i = 0; i < col; i++) begin : g_col
    logic [aw:0]        wptr;
    logic [aw:0]        rptr;
    logic [psum_bw-1:0] mem [depth];
    logic               push;

    assign full[i]     = (wptr[aw] != rptr[aw]) && (wptr[aw-1:0] == rptr[aw-1:0]);
    assign nonempty[i] = (wptr != rptr);
    assign push        = wr[i] & ~full[i];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) wptr <= wptr + ptr_one;
        if (pop)  rptr <= rptr + ptr_one;
      end
    end

    // Storage is not reset; emptiness is tracked purely by the pointers.
    always_ff @(posedge clk) begin
      if (push) mem[wptr[aw-1:0]] <= in[i*psum_bw +: psum_bw];
    end

    assign out[i*psum_bw +: psum_bw] = mem[rptr[aw-1:0]];
  end

`ifdef PSUM_COLLECTOR_OVF_FLAG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              o_ovf <= 1'b0;
    else if (|(wr & full))  o_ovf <= 1'b1;
  end
`endif

endmodule

// File: doc/psum_collector.md
PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 SHALL have parameter col, default 8: number of columns, matching the upstream MAC row width.
REQ-002 SHALL have parameter psum_bw, default 16: partial-sum width per column.
REQ-003 SHALL have parameter depth, default 8: entries per column FIFO; power of two, minimum 2.
REQ-004 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port in, input, psum_bw*col: column i psum on bits [psum_bw*(i+1)-1 : psum_bw*i].
REQ-007 SHALL have port wr, input, col: per-column write strobe, driven by the MAC row per-column valid.
REQ-008 SHALL have port rd, input, 1: pop one full row.
REQ-009 SHALL have port out, output, psum_bw*col: head entry of every column FIFO, same packing as in.
REQ-010 SHALL have port o_valid, output, 1: every column FIFO is non-empty.
REQ-011 SHALL have port o_full, output, 1: at least one column FIFO is full.
REQ-012 SHALL have port o_ready, output, 1: no column FIFO is full.

Function
REQ-013 SHALL hold col independent FIFOs, each depth x psum_bw, with wptr/rptr of log2(depth)+1 bits.
- Empty when pointers are equal.
- Full when pointer MSBs differ and the lower bits are equal.
REQ-014 SHALL write in slice i into column i at a clock edge when wr[i]=1 and column i was not full before that edge; columns write independently, since upstream valids arrive skewed by one cycle per column.
REQ-015 SHALL drop a write to a full column.
- The column's contents and pointers SHALL NOT change.
- The full test uses pre-edge state, so a write to a full column is dropped even when rd pops that column in the same cycle.
REQ-016 SHALL drive o_valid combinationally as the AND of all column non-empty flags.
REQ-017 SHALL, when rd=1 and o_valid=1, advance every column rptr by one at the clock edge.
REQ-018 SHALL ignore rd when o_valid=0; no pointer moves.
REQ-019 SHALL present out first-word-fall-through: out equals the head entries, valid whenever o_valid=1.
REQ-020 SHALL make a row visible the cycle after its last column write: write at edge N, o_valid=1 after edge N.
REQ-021 SHALL, on simultaneous read and write to a non-full, non-empty column, perform both; occupancy is unchanged.
REQ-022 SHALL wrap pointers modulo 2*depth, with storage indexed by the lower log2(depth) bits.
REQ-023 SHALL drive o_full as the OR of column full flags, and o_ready as NOT o_full.
REQ-024 SHALL leave out undefined-don't-care while o_valid=0; checkers mask it.

Reset
REQ-025 SHALL, while reset=1, asynchronously clear all pointers, giving o_valid=0, o_full=0, o_ready=1.
REQ-026 SHALL discard all stored rows on a mid-operation reset; storage contents need not be cleared.
REQ-027 SHALL accept writes beginning on the first rising clk edge after reset deasserts.

Configuration
REQ-028 SHALL, with macro PSUM_COLLECTOR_OVF_FLAG_EN defined, add output o_ovf (1 bit).
- o_ovf is a sticky flag, set on the edge of any dropped write (REQ-015).
- It is cleared only by reset.
REQ-029 SHALL, without PSUM_COLLECTOR_OVF_FLAG_EN, omit the o_ovf port and its register; all other behaviour is identical.

Verification
REQ-030 SHALL cover skewed fill: wr=8'h01, 8'h03, ... 8'hFF on successive cycles with in slice i = i+1 -> o_valid rises only after the 8'hFF edge; out = {16'd8,...,16'd1}.
REQ-031 SHALL cover full: 8 full rows written with no rd -> o_full=1, o_ready=0; a 9th row is dropped; 8 pops return rows 0..7 in order, then o_valid=0.
REQ-032 SHALL cover simultaneous traffic: 4 rows stored, then rd=1 and wr=8'hFF for 10 cycles -> occupancy stays 4 and outputs stay in order (rows 0..9 emerge).
REQ-033 SHALL cover read when empty: rd=1 with column 7 empty and columns 0-6 holding 1 entry -> no pointer change; o_valid stays 0 until wr[7].
REQ-034 SHALL cover reset mid-operation: 5 rows stored, reset pulsed between edges -> o_valid=0 and o_ready=1 immediately; the next written row reads back first.
REQ-035 SHALL cover overflow, with PSUM_COLLECTOR_OVF_FLAG_EN defined: write to full column 3 -> o_ovf=1 after that edge and held through later pops until reset.
